program_store: RTL
==================

// Module: program_store
// PURPOSE
//  Writable, multi-bank instruction memory for the calculator CPU.
//  Parametrised successor to the fixed combinational program ROM.
//  The CPU fetches through a registered read port; a bank select replaces the single signed/unsigned mode bit.
//  A loader streams new programs into any bank through a valid/ready handshake.
// PARAMETERS
//  DATA_W    32     instruction width in bits
//  ADDR_W    8      word address width; DEPTH = 2**ADDR_W words per bank
//  BANK_W    1      bank select width; BANKS = 2**BANK_W
//  FILL_WORD 32'd0  word written by post-reset clear (NOP)
// PORTS
//  clk           in   1          single clock, rising edge
//  reset_n       in   1          synchronous, active-low reset
//  fetch_req     in   1          fetch strobe
//  fetch_addr    in   ADDR_W     word address
//  fetch_bank    in   BANK_W     bank to read (0 = signed program, 1 = unsigned)
//  instruction   out  DATA_W     registered fetch data
//  instr_valid   out  1          instruction is valid this cycle
//  fetch_stall   out  1          fetch hit the bank being cleared or loaded
//  load_start    in   1          pulse: begin load of load_len words
//  load_bank     in   BANK_W     target bank, sampled on load_start
//  load_base     in   ADDR_W     first word address, sampled on load_start
//  load_len      in   ADDR_W+1   word count 1..DEPTH, sampled on load_start
//  load_data     in   DATA_W     word to write
//  load_valid    in   1          load_data is valid
//  load_ready    out  1          store accepts load_data
//  load_done     out  1          one-cycle pulse after the last word is written
//  load_wrapped  out  1          sticky: load address wrapped past DEPTH-1
//  busy          out  1          FSM is not in IDLE
//  parity_err    out  1          one-cycle pulse on parity mismatch (macro only)
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge): all outputs 0, FSM goes to CLEAR, clear counter set to 0.
//  FSM states:
//   CLEAR: writes FILL_WORD to one address per cycle, all banks in parallel.
//     Takes DEPTH cycles, busy=1, load_ready=0, load_start ignored; then goes to IDLE.
//   IDLE: load_start with load_len in 1..DEPTH latches bank/base/len, goes to LOAD.
//     load_len=0 or >DEPTH: request ignored, stays in IDLE.
//   LOAD: load_ready=1. Each cycle with load_valid & load_ready writes one word at the pointer.
//     Pointer increments mod DEPTH. Passing DEPTH-1 -> 0 sets load_wrapped.
//     On the final word: next cycle goes to IDLE and pulses load_done.
//     load_start during LOAD is ignored.
//  Fetch: registered read, latency 1. Address and bank are sampled on fetch_req.
//   Next cycle: instruction = mem[bank][addr] and instr_valid=1.
//   No fetch_req: instr_valid=0 and instruction holds its last value.
//   Fetch in CLEAR, or fetch of the loading bank during LOAD:
//     next cycle instruction=FILL_WORD, instr_valid=1, fetch_stall=1.
//   Fetch of any other bank during LOAD is served normally.
//  Same-cycle fetch and write to the same bank/addr cannot occur (that access stalls instead).
//  load_wrapped clears on reset or on an accepted load_start.
//  Reset mid-LOAD: the partial load is discarded, clear restarts, load_done does not fire.
// CONFIGURATION
//  PROGRAM_PARITY_EN defined:
//   - Each word stores an extra even-parity bit, computed on write.
//   - On fetch the parity is checked; on mismatch: instruction=FILL_WORD, instr_valid=1,
//     parity_err pulses alongside instr_valid.
//  PROGRAM_PARITY_EN undefined: no parity storage, parity_err tied to 0.
// TESTING
//  1 Release reset, fetch bank0 addr 5 before busy falls -> fetch_stall=1, instruction=0.
//    busy falls after 256 cycles.
//  2 Load bank1, base 10, len 3, data A1/B2/C3 with gaps in load_valid.
//    -> bank1 fetches of 10/11/12 return them one cycle later; load_done pulses once.
//  3 Load bank0, base 254, len 4.
//    -> words land at 254, 255, 0, 1; load_wrapped=1; the next load_start clears it.
//  4 During a bank1 load: fetch bank0 addr 10 -> normal data, no stall.
//    Fetch bank1 addr 10 -> FILL_WORD with fetch_stall=1.
//  5 load_start with load_len=0 or 257 -> busy stays 0, no writes.
//    Reset after 2 of 4 words -> the store re-clears; those addresses read FILL_WORD.
//  6 PROGRAM_PARITY_EN: force a parity bit flip at addr 7
//    -> fetch gives parity_err=1 and instruction=FILL_WORD.

Source files
------------

// File: rtl/program_store.sv
// Multi-bank writable instruction store: registered fetch port, post-reset clear, streaming loader.
// Optional PROGRAM_PARITY_EN macro adds a per-word even-parity bit checked on fetch.
module program_store #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = 8,
    parameter int unsigned       BANK_W    = 1,
    parameter logic [DATA_W-1:0] FILL_WORD = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic [BANK_W-1:0] fetch_bank,
    output logic [DATA_W-1:0] instruction,
    output logic              instr_valid,
    output logic              fetch_stall,
    input  logic              load_start,
    input  logic [BANK_W-1:0] load_bank,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_len,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              load_done,
    output logic              load_wrapped,
    output logic              busy,
    output logic              parity_err
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned BANKS = 1 << BANK_W;
    localparam int unsigned LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2
    } state_e;

    // Banks are stacked into one array addressed by {bank, addr}
    logic [DATA_W-1:0] mem_q [BANKS*DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [BANK_W-1:0] ld_bank_q, ld_bank_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              stall_q, stall_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              wrapped_q, wrapped_d;
    logic              busy_q, busy_d;
    logic              clr_we;
    logic              ld_we;
    logic              len_ok;
    logic              fetch_blocked;
    logic [DATA_W-1:0] rd_word;

`ifdef PROGRAM_PARITY_EN
    logic              par_q [BANKS*DEPTH];
    logic              perr_q, perr_d;
    logic              rd_par;
`endif

    assign len_ok        = (load_len != '0) && (load_len <= LEN_W'(DEPTH));
    assign fetch_blocked = (state_q == ST_CLEAR) ||
                           ((state_q == ST_LOAD) && (fetch_bank == ld_bank_q));
    assign rd_word       = mem_q[{fetch_bank, fetch_addr}];

    // Next-state, loader bookkeeping and fetch response
    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        ld_bank_d     = ld_bank_q;
        ptr_d         = ptr_q;
        rem_d         = rem_q;
        instr_d       = instr_q;
        instr_valid_d = 1'b0;
        stall_d       = 1'b0;
        done_d        = 1'b0;
        wrapped_d     = wrapped_q;
        clr_we        = 1'b0;
        ld_we         = 1'b0;
`ifdef PROGRAM_PARITY_EN
        perr_d        = 1'b0;
        rd_par        = par_q[{fetch_bank, fetch_addr}];
`endif

        case (state_q)
            ST_CLEAR: begin
                clr_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                if (clr_cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (load_start && len_ok) begin
                    ld_bank_d = load_bank;
                    ptr_d     = load_base;
                    rem_d     = load_len;
                    wrapped_d = 1'b0;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_valid && ready_q) begin
                    ld_we = 1'b1;
                    ptr_d = ptr_q + ADDR_W'(1);
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                        wrapped_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase

        if (fetch_req) begin
            instr_valid_d = 1'b1;
            if (fetch_blocked) begin
                instr_d = FILL_WORD;
                stall_d = 1'b1;
            end else begin
                instr_d = rd_word;
`ifdef PROGRAM_PARITY_EN
                if ((^rd_word) != rd_par) begin
                    instr_d = FILL_WORD;
                    perr_d  = 1'b1;
                end
`endif
            end
        end

        ready_d = (state_d == ST_LOAD);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_CLEAR;
            clr_cnt_q     <= '0;
            ld_bank_q     <= '0;
            ptr_q         <= '0;
            rem_q         <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            stall_q       <= 1'b0;
            ready_q       <= 1'b0;
            done_q        <= 1'b0;
            wrapped_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            ld_bank_q     <= ld_bank_d;
            ptr_q         <= ptr_d;
            rem_q         <= rem_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            stall_q       <= stall_d;
            ready_q       <= ready_d;
            done_q        <= done_d;
            wrapped_q     <= wrapped_d;
            busy_q        <= busy_d;
        end
    end

    // Storage writes: clear hits every bank at once, loader hits one word
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (clr_we) begin
                for (int b = 0; b < int'(BANKS); b++) begin
                    mem_q[{BANK_W'(b), clr_cnt_q}] <= FILL_WORD;
                end
            end
            if (ld_we) begin
                mem_q[{ld_bank_q, ptr_q}] <= load_data;
            end
        end
    end

`ifdef PROGRAM_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (clr_we) begin
                for (int b = 0; b < int'(BANKS); b++) begin
                    par_q[{BANK_W'(b), clr_cnt_q}] <= ^FILL_WORD;
                end
            end
            if (ld_we) begin
                par_q[{ld_bank_q, ptr_q}] <= ^load_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    assign instruction  = instr_q;
    assign instr_valid  = instr_valid_q;
    assign fetch_stall  = stall_q;
    assign load_ready   = ready_q;
    assign load_done    = done_q;
    assign load_wrapped = wrapped_q;
    assign busy         = busy_q;

endmodule
